// File: rtl/data_memory_p.sv
// Single-port word memory that zero-fills itself after reset, then serves 1-cycle-latency reads and writes.
// Optional byte-lane write strobes are compiled in with DMEM_BYTE_WRITE_EN.
module data_memory_p #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 16,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req,
  input  logic                we,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wdata,
`ifdef DMEM_BYTE_WRITE_EN
  input  logic [DATA_W/8-1:0] be,
`endif
  output logic                ready,
  output logic                busy,
  output logic                rvalid,
  output logic [DATA_W-1:0]   rdata,
  output logic                err
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int LANES = DATA_W / 8;

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t                state, state_nxt;
  logic [DEPTH_LOG2-1:0] clr_cnt;
  logic [DATA_W-1:0]     mem [DEPTH];
  logic [DEPTH_LOG2-1:0] idx;
  logic                  oor;
  logic                  accept;
  logic [LANES-1:0]      lane_en;
  logic                  rvalid_q;
  logic                  err_q;
  logic [DATA_W-1:0]     rdata_q;

  assign idx    = addr[DEPTH_LOG2-1:0];
  assign oor    = (addr >> DEPTH_LOG2) != '0;
  // Gating with rst keeps the block closed during the reset cycle itself.
  assign ready  = (state == IDLE) && !rst;
  assign busy   = !ready;
  assign accept = req && ready;

`ifdef DMEM_BYTE_WRITE_EN
  assign lane_en = be;
`else
  assign lane_en = '1;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= CLEAR;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      CLEAR:   if (clr_cnt == {DEPTH_LOG2{1'b1}}) state_nxt = IDLE;
      IDLE:    state_nxt = IDLE;
      default: state_nxt = CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)                 clr_cnt <= '0;
    else if (state == CLEAR) clr_cnt <= clr_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEAR) begin
        mem[clr_cnt] <= '0;
      end else if (accept && we && !oor) begin
        for (int i = 0; i < LANES; i++) begin
          if (lane_en[i]) mem[idx][i*8 +: 8] <= wdata[i*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= accept && !we;
      err_q    <= accept && oor;
      if (accept && !we) rdata_q <= oor ? '0 : mem[idx];
    end
  end

  // A response pending when rst rises is suppressed, not delivered late.
  assign rvalid = rvalid_q && !rst;
  assign err    = err_q && !rst;
  assign rdata  = rst ? '0 : rdata_q;

endmodule

// File: tb/tb_data_memory_p.sv
// Randomized scoreboard bench for data_memory_p against an array-based reference memory.
module tb_data_memory_p;

  typedef struct packed {
    logic        rv;
    logic        er;
    logic [15:0] d;
  } resp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [15:0] addr = '0;
  logic [15:0] wdata = '0;
  logic [1:0]  be = 2'b11;
  logic        ready, busy, rvalid, err;
  logic [15:0] rdata;

  int          n_cmp = 0;
  int          n_fail = 0;
  resp_t       exp_q[$];
  logic [15:0] ref_mem [1024];
  logic [15:0] hold_rdata = '0;

  always #5 clk = ~clk;

  data_memory_p #(.DATA_W(16), .ADDR_W(16), .DEPTH_LOG2(10)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
`ifdef DMEM_BYTE_WRITE_EN
    .be(be),
`endif
    .ready(ready), .busy(busy), .rvalid(rvalid), .rdata(rdata), .err(err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    foreach (ref_mem[i]) ref_mem[i] = 16'h0;
  endtask

  // Issue one access on a cycle the bench knows the memory is idle.
  task automatic acc(input bit w, input logic [15:0] a, input logic [15:0] d, input logic [1:0] b);
    bit    in_range;
    resp_t r;
    req = 1'b1; we = w; addr = a; wdata = d; be = b;
    in_range = (a < 16'd1024);
    if (w) begin
      if (in_range) begin
`ifdef DMEM_BYTE_WRITE_EN
        if (b[0]) ref_mem[a][7:0]  = d[7:0];
        if (b[1]) ref_mem[a][15:8] = d[15:8];
`else
        ref_mem[a] = d;
`endif
      end else begin
        r = '{rv: 1'b0, er: 1'b1, d: 16'h0};
        exp_q.push_back(r);
      end
    end else begin
      r = '{rv: 1'b1, er: !in_range, d: in_range ? ref_mem[a] : 16'h0};
      exp_q.push_back(r);
    end
    step();
  endtask

  task automatic idle(input int n);
    req = 1'b0;
    repeat (n) step();
  endtask

  task automatic wait_clear(input string name);
    int cycles = 0;
    while (busy && cycles < 2000) begin
      cycles++;
      step();
    end
    chk(name, cycles, 1024);
    chk({name, "_ready"}, ready, 1'b1);
  endtask

  // Monitor: every response pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_rvalid", rvalid, 1'b0);
      chk("rst_err", err, 1'b0);
      hold_rdata = 16'h0;
    end else if (rvalid || err) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", {rvalid, err}, 2'b00);
      end else begin
        resp_t e;
        e = exp_q.pop_front();
        chk("resp_rvalid", rvalid, e.rv);
        chk("resp_err", err, e.er);
        if (e.rv) begin
          chk("resp_rdata", rdata, e.d);
          hold_rdata = e.d;
        end else begin
          chk("hold_rdata_err", rdata, hold_rdata);
        end
      end
    end else begin
      chk("hold_rdata", rdata, hold_rdata);
    end
  end

  initial begin
    model_clear();
    repeat (3) step();
    chk("reset_ready", ready, 1'b0);
    chk("reset_busy", busy, 1'b1);
    chk("reset_rvalid", rvalid, 1'b0);
    chk("reset_err", err, 1'b0);
    chk("reset_rdata", rdata, 16'h0);

    // Request held through the whole clear; must not be taken early.
    rst = 1'b0; req = 1'b1; we = 1'b0; addr = 16'd5;
    wait_clear("clear_len_first");
    acc(1'b0, 16'd5, 16'h0, 2'b11);

    acc(1'b1, 16'h03FF, 16'hBEEF, 2'b11);
    acc(1'b0, 16'h03FF, 16'h0, 2'b11);
    acc(1'b1, 16'h0400, 16'h1234, 2'b11);
    acc(1'b0, 16'h0000, 16'h0, 2'b11);
    acc(1'b0, 16'h0400, 16'h0, 2'b11);
    idle(2);

    for (int i = 0; i < 400; i++) begin
      logic [15:0] a;
      case ($urandom_range(0, 9))
        0:       a = 16'($urandom_range(1024, 65535));
        1, 2, 3: a = 16'($urandom_range(0, 15));
        default: a = 16'($urandom_range(0, 1023));
      endcase
      acc(1'($urandom_range(0, 1)), a, 16'($urandom), 2'($urandom_range(0, 3)));
      if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 2));
    end
    idle(2);

    acc(1'b1, 16'd9, 16'hFFFF, 2'b11);
    acc(1'b1, 16'd9, 16'h1200, 2'b10);
    acc(1'b0, 16'd9, 16'h0, 2'b11);
    acc(1'b1, 16'd9, 16'h5678, 2'b00);
    acc(1'b0, 16'd9, 16'h0, 2'b11);
    idle(2);

    // Reset on the cycle after a read is accepted: its response must vanish.
    acc(1'b1, 16'd7, 16'hAAAA, 2'b11);
    acc(1'b0, 16'd7, 16'h0, 2'b11);
    rst = 1'b1; req = 1'b0;
    exp_q.delete();
    model_clear();
    step();
    chk("rst_busy", busy, 1'b1);
    chk("rst_ready", ready, 1'b0);
    rst = 1'b0;
    repeat (300) step();
    chk("mid_clear_busy", busy, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    wait_clear("clear_len_restart");
    acc(1'b0, 16'd7, 16'h0, 2'b11);
    acc(1'b0, 16'd300, 16'h0, 2'b11);
    idle(4);

    chk("outstanding_responses", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/data_memory_p.md
DATA_MEMORY_P -- requirements
Module: data_memory_p

Interface
REQ-001 The block SHALL take parameter DATA_W, default 16, data word width in bits (multiple of 8).
REQ-002 The block SHALL take parameter ADDR_W, default 16, width of the word address bus.
REQ-003 The block SHALL take parameter DEPTH_LOG2, default 10, giving 2**DEPTH_LOG2 words, with DEPTH_LOG2 <= ADDR_W.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 req  input  1  access request, valid when high.
REQ-007 we  input  1  with req: 1 = write, 0 = read.
REQ-008 addr  input  ADDR_W  word address.
REQ-009 wdata  input  DATA_W  write data.
REQ-010 be  input  DATA_W/8  byte-lane write strobes; present only when DMEM_BYTE_WRITE_EN is defined.
REQ-011 ready  output  1  block accepts req this cycle.
REQ-012 busy  output  1  clear sequence in progress.
REQ-013 rvalid  output  1  one-cycle pulse, rdata/err valid.
REQ-014 rdata  output  DATA_W  read data.
REQ-015 err  output  1  one-cycle pulse, out-of-range access.

Function
REQ-016 The block SHALL implement two states, CLEAR and IDLE, where ready = (state == IDLE) and busy = (state == CLEAR).
REQ-017 In CLEAR, a DEPTH_LOG2-bit counter SHALL write 0 to word[counter] each cycle from 0 up to 2**DEPTH_LOG2-1, then transition to IDLE on the following edge (DEPTH cycles in CLEAR).
REQ-018 A request SHALL be accepted only on a cycle with req=1 and ready=1; req during CLEAR SHALL be ignored with no side effect and no later replay.
REQ-019 An accepted write with addr < 2**DEPTH_LOG2 SHALL update the word at the clock edge of acceptance, produce no rvalid, and leave rdata unchanged.
REQ-020 An accepted read SHALL be synchronous with latency 1: rvalid=1 and rdata=word[addr] in the cycle after acceptance.
REQ-021 Back-to-back accepts SHALL be supported every cycle; a read following a write to the same address SHALL return the newly written data.
REQ-022 An access with any addr bit at position DEPTH_LOG2 or above set SHALL be out-of-range.
REQ-023 An out-of-range write SHALL be dropped, with err=1 in the next cycle and rvalid=0.
REQ-024 An out-of-range read SHALL give rvalid=1, err=1 and rdata=0 in the next cycle.
REQ-025 rdata SHALL hold its last value between reads.
REQ-026 rvalid and err SHALL be 0 on every cycle not immediately following an accepted access.

Reset
REQ-027 While rst=1: state=CLEAR, counter=0, rvalid=0, err=0, rdata=0, ready=0, busy=1.
REQ-028 On release of rst, the clear sequence SHALL restart from word 0.
REQ-029 rst asserted mid-CLEAR or during an access SHALL abort it; the pending rvalid/err SHALL be suppressed and the full clear SHALL restart.

Configuration
REQ-030 With DMEM_BYTE_WRITE_EN defined, an accepted in-range write SHALL update only the byte lanes i where be[i]=1; be=0 SHALL leave the word unchanged (no err); the clear sequence SHALL ignore be.
REQ-031 Without DMEM_BYTE_WRITE_EN, the be port SHALL be absent and every in-range write SHALL update the full word.

Verification
REQ-032 Release rst, hold req=1 with a read of addr 5 -> busy=1 and ready=0 for exactly 1024 cycles, then accepted; rvalid=1 with rdata=0x0000 one cycle later.
REQ-033 Write 0xBEEF to 0x03FF, next cycle read 0x03FF -> rvalid=1 with rdata=0xBEEF one cycle after the read; err=0.
REQ-034 Write 0x1234 to 0x0400, then read 0x0000 -> err pulse after the write with no rvalid, then rvalid=1, err=0, rdata=0x0000; a read of 0x0400 gives rvalid=1, err=1, rdata=0.
REQ-035 Write 0xAAAA to 7; assert rst for 1 cycle at clear counter 300; after re-clear, read 7 -> 0x0000; busy lasts 1024 cycles after the rst release.
REQ-036 With DMEM_BYTE_WRITE_EN: write 0xFFFF to 9, then write 0x1200 with be=2'b10 -> read 9 returns 0x12FF; be=2'b00 write leaves 0x12FF.
